// File: rtl/fp32_mul_req_pkg.sv
// Shared types and constants for the FP32 multiplier requester.
package fp32_mul_req_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        HOLD  = 2'd3
    } state_t;

    localparam logic [31:0] FP32_QNAN = 32'h7FC0_0000;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
    } operand_pair_t;

endpackage

// File: rtl/fp32_mul_requester_fifo.sv
// Synchronous FIFO holding queued operand pairs; head is visible combinationally on o_data.
module sync_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_data,
    output logic             o_full,
    output logic             o_empty
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W:0]   r_count;
    logic             w_push;
    logic             w_pop;

    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;
    assign o_full  = (r_count == (PTR_W+1)'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_data  = r_mem[r_rd_ptr];

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // NOTE: storage is deliberately not reset; the empty flag keeps stale entries from being read.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= i_data;
    end

endmodule

// File: rtl/fp32_mul_requester.sv
// Queues FP32 operand pairs, issues them to the multiplier one at a time, and
// returns each product (or a watchdog QNaN) on a valid/ready response port.
module fp32_mul_requester #(
    parameter int DEPTH          = 4,
    parameter int TIMEOUT_CYCLES = 64,
    parameter int CNT_W          = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [31:0]      cmd_a,
    input  logic [31:0]      cmd_b,
    output logic             mul_datain_valid,
    input  logic             mul_datain_ready,
    output logic [31:0]      mul_datain1,
    output logic [31:0]      mul_datain2,
    input  logic [31:0]      mul_dataout,
    input  logic             mul_dataout_valid,
    input  logic             mul_overflow_flag,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [31:0]      rsp_data,
    output logic             rsp_overflow,
    output logic             rsp_timeout,
    output logic             err_stray,
    output logic [CNT_W-1:0] done_count
);

    import fp32_mul_req_pkg::*;

    localparam int WD_W = $clog2(TIMEOUT_CYCLES);

    state_t           r_state;
    state_t           w_next_state;
    operand_pair_t    w_cmd_pair;
    operand_pair_t    w_fifo_head;
    operand_pair_t    r_operands;
    logic             w_fifo_full;
    logic             w_fifo_empty;
    logic             w_push;
    logic             w_pop;
    logic [WD_W-1:0]  r_watchdog;
    logic             w_wd_expired;
    logic [31:0]      r_rsp_data;
    logic             r_rsp_overflow;
    logic             r_rsp_timeout;
    logic             r_err_stray;
    logic [CNT_W-1:0] r_done_count;

    assign w_cmd_pair   = '{a: cmd_a, b: cmd_b};
    assign w_push       = cmd_valid && cmd_ready;
    assign w_wd_expired = (r_watchdog == WD_W'(TIMEOUT_CYCLES - 1));

    sync_fifo #(
        .WIDTH ($bits(operand_pair_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_push  (w_push),
        .i_data  (w_cmd_pair),
        .i_pop   (w_pop),
        .o_data  (w_fifo_head),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty)
    );

    // NOTE: every sequential assignment is non-blocking so all registers update from pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_next_state;
    end

    // NOTE: the default assignment first keeps this block free of inferred latches.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (!w_fifo_empty) w_next_state = ISSUE;
            ISSUE:   if (mul_datain_ready) w_next_state = WAIT;
            WAIT:    if (mul_dataout_valid || w_wd_expired) w_next_state = HOLD;
            HOLD:    if (rsp_ready) w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    always_comb begin
        mul_datain_valid = (r_state == ISSUE);
        rsp_valid        = (r_state == HOLD);
        w_pop            = (r_state == IDLE) && !w_fifo_empty;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_operands     <= '0;
            r_watchdog     <= '0;
            r_rsp_data     <= '0;
            r_rsp_overflow <= 1'b0;
            r_rsp_timeout  <= 1'b0;
            r_err_stray    <= 1'b0;
            r_done_count   <= '0;
        end else begin
            if (w_pop) r_operands <= w_fifo_head;

            if (r_state == ISSUE && mul_datain_ready) r_watchdog <= '0;
            else if (r_state == WAIT)                 r_watchdog <= r_watchdog + 1'b1;

            // A real product always beats a watchdog expiry landing on the same edge.
            if (r_state == WAIT) begin
                if (mul_dataout_valid) begin
                    r_rsp_data     <= mul_dataout;
                    r_rsp_overflow <= mul_overflow_flag;
                    r_rsp_timeout  <= 1'b0;
                end else if (w_wd_expired) begin
                    r_rsp_data     <= FP32_QNAN;
                    r_rsp_overflow <= 1'b0;
                    r_rsp_timeout  <= 1'b1;
                end
            end

            if (r_state == HOLD && rsp_ready) r_done_count <= r_done_count + 1'b1;
            if (mul_dataout_valid && r_state != WAIT) r_err_stray <= 1'b1;
        end
    end

    assign cmd_ready    = !w_fifo_full;
    assign mul_datain1  = r_operands.a;
    assign mul_datain2  = r_operands.b;
    assign rsp_data     = r_rsp_data;
    assign rsp_overflow = r_rsp_overflow;
    assign rsp_timeout  = r_rsp_timeout;
    assign err_stray    = r_err_stray;
    assign done_count   = r_done_count;

endmodule
